ball_mover: RTL
===============

// Module: ball_mover
// PURPOSE
//  Upstream of the map sprite renderer: owns the ball's map-cell position (ballx/bally) and feeds it to the renderer.
//  Once every FRAMES_PER_STEP frames it steps the ball one cell in the commanded direction.
//  Each step is checked against the map via a read-only port on the map BRAM (4-bit tiles); walls block, goal freezes.
// PARAMETERS
//  MAP_W           128  map width in cells (power of two); address = x + y*MAP_W
//  MAP_H           128  map height in cells
//  FRAMES_PER_STEP 4    frame ticks per movement opportunity (>=1)
//  RD_LAT          2    map read latency in cycles, addr -> data (HIGH_PERFORMANCE BRAM)
//  START_X         1    reset/restart cell x
//  START_Y         1    reset/restart cell y
// PORTS
//  pixel_clk_in      in   1   pixel clock; sole clock
//  rst_in            in   1   asynchronous, ACTIVE-LOW reset
//  frame_tick_in     in   1   one-cycle pulse per frame (end of active video)
//  dir_in            in   4   {up,down,left,right} buttons, synchronised upstream
//  restart_in        in   1   synchronous restart pulse
//  map_addr_out      out  14  map read address
//  map_data_in       in   4   tile at map_addr_out, RD_LAT cycles later
//  ballx_out         out  7   ball cell x (to renderer ballx)
//  bally_out         out  7   ball cell y (to renderer bally)
//  busy_out          out  1   step evaluation in flight
//  moved_out         out  1   one-cycle pulse: position committed
//  bump_out          out  1   one-cycle pulse: step blocked (wall or map edge)
//  goal_out          out  1   sticky: ball reached goal tile
// BEHAVIOUR
//  Reset (rst_in=0): ball=(START_X,START_Y), frame counter=0, state IDLE, map_addr_out=0, all pulses/flags 0.
//  Tiles: 0 FLOOR, 1 WALL, 2 GOAL; any other value treated as FLOOR.
//  IDLE: on frame_tick_in, counter increments; at FRAMES_PER_STEP-1 it wraps to 0 and, if dir_in!=0 and goal_out=0,
//   latch one direction by priority up>down>left>right -> CALC. Ticks outside IDLE are dropped (counter frozen).
//  CALC (1 cycle): target = ball +/-1 on one axis. Edge move (x=0 left, x=MAP_W-1 right, y=0 up, y=MAP_H-1 down)
//   -> bump_out pulse, back to IDLE, no map read. Else map_addr_out<=target addr -> WAIT.
//  WAIT: hold map_addr_out for RD_LAT cycles (cycle counter) -> CHECK.
//  CHECK (1 cycle): WALL -> bump_out. Else ball<=target, moved_out; GOAL additionally sets goal_out. -> IDLE.
//  busy_out=1 in CALC/WAIT/CHECK. Tick-to-commit latency = RD_LAT+2 cycles; ballx/bally change only in CHECK.
//  goal_out=1 freezes movement (ticks still counted) until restart_in or reset.
//  restart_in (any state, priority over everything incl. tick same cycle): ball=start, counter=0, goal_out=0,
//   in-flight step aborted (no moved/bump pulse), state IDLE.
//  ballx/bally registered outputs; address arithmetic done at 14 bits, no truncation.
// STRUCTURE
//  Package map_pkg: MAP_W/MAP_H defaults, tile_t enum (FLOOR/WALL/GOAL), dir_t enum, cell_addr() function.
//  One sub-module: step_divider (frame-tick counter, emits step_en on wrap, sync clear from restart).
//  FSM states IDLE/CALC/WAIT/CHECK in ball_mover; map BRAM instantiated by top level, its read port wired here.
// TESTING (bench models map BRAM with RD_LAT=2 from a small init map)
//  1 Reset, FRAMES_PER_STEP=4, dir=right, 4 ticks, floor at (2,1) -> moved_out 4 cycles after 4th tick, ball=(2,1), map_addr=130.
//  2 Wall at (1,0), dir=up at step -> bump_out pulse, ball stays (1,1), moved_out never asserts.
//  3 Ball at (0,5), dir=left -> bump_out in CALC cycle, no address change, busy_out only 1 cycle.
//  4 dir=up|right simultaneously -> up chosen; goal tile at target -> goal_out=1, further steps ignored.
//  5 restart_in during WAIT -> no pulses, ball=(1,1), goal_out=0, next step needs full 4 ticks.
//  6 rst_in low mid-WAIT (async, off-edge) -> outputs at reset values immediately; ticks during busy ignored.

Source files
------------

// File: rtl/map_pkg.sv
// Shared map geometry, tile/direction encodings and address helpers for the ball mover.
package map_pkg;

    localparam int MAP_W_DFLT = 128;
    localparam int MAP_H_DFLT = 128;
    localparam int COORD_W    = 7;
    localparam int ADDR_W     = 14;
    localparam int TILE_W     = 4;

    typedef enum logic [TILE_W-1:0] {
        TILE_FLOOR = 4'd0,
        TILE_WALL  = 4'd1,
        TILE_GOAL  = 4'd2
    } tile_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [ADDR_W-1:0]  w
    );
        return ADDR_W'(x) + ADDR_W'(y) * w;
    endfunction

    // Buttons arrive as {up,down,left,right}; up wins, right is the fallback.
    function automatic dir_t pick_dir(input logic [3:0] btn);
        if (btn[3])      return DIR_UP;
        else if (btn[2]) return DIR_DOWN;
        else if (btn[1]) return DIR_LEFT;
        else             return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/ball_mover_if.sv
// Read-only port into the map BRAM: ball_mover drives the address, the BRAM returns the tile.
interface ball_mover_if;
    logic [map_pkg::ADDR_W-1:0] map_addr_out;
    logic [map_pkg::TILE_W-1:0] map_data_in;

    modport master (output map_addr_out, input  map_data_in);
    modport slave  (input  map_addr_out, output map_data_in);
endinterface

// File: rtl/step_divider.sv
// Frame-tick divider: counts enabled ticks and flags the tick that wraps the count.
module step_divider #(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_tick,
    output logic o_step_en
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(FRAMES_PER_STEP - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_adv;

    // A clear in the same cycle as a tick wins: the tick is not counted.
    assign w_adv     = i_tick & i_en & ~i_clr;
    assign o_step_en = w_adv & (r_cnt == TC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_adv) begin
            r_cnt <= (r_cnt == TC) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ball_mover.sv
// Owns the ball's map cell; every FRAMES_PER_STEP frames tries one step, checked against the map tile.
//   state    | meaning
//   ST_IDLE  | counting frame ticks, waiting for a movement opportunity
//   ST_CALC  | target cell computed; map edge -> bump, else issue map read
//   ST_WAIT  | holding map address for RD_LAT cycles
//   ST_CHECK | tile valid: wall -> bump, else commit move (goal sets sticky flag)
module ball_mover
    import map_pkg::*;
#(
    parameter int MAP_W           = MAP_W_DFLT,
    parameter int MAP_H           = MAP_H_DFLT,
    parameter int FRAMES_PER_STEP = 4,
    parameter int RD_LAT          = 2,
    parameter int START_X         = 1,
    parameter int START_Y         = 1
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    input  logic               frame_tick_in,
    input  logic [3:0]         dir_in,
    input  logic               restart_in,
    ball_mover_if.master       map_if,
    output logic [COORD_W-1:0] ballx_out,
    output logic [COORD_W-1:0] bally_out,
    output logic               busy_out,
    output logic               moved_out,
    output logic               bump_out,
    output logic               goal_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_WAIT, ST_CHECK} state_t;

    localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(MAP_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(MAP_H - 1);
    localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);

    state_t             r_state, w_state_nxt;
    dir_t               r_dir;
    logic [WC_W-1:0]    r_wcnt;
    logic [ADDR_W-1:0]  r_map_addr;
    logic [COORD_W-1:0] r_bx, r_by;
    logic [COORD_W-1:0] w_tx, w_ty;
    logic               r_moved, r_bump, r_goal;
    logic               w_idle, w_step_en, w_go, w_edge, w_busy;

    assign w_idle = (r_state == ST_IDLE);
    assign w_go   = w_step_en & (dir_in != 4'b0000) & ~r_goal;

    step_divider #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_step_divider (
        .i_clk     (pixel_clk_in),
        .i_rst_n   (rst_in),
        .i_clr     (restart_in),
        .i_en      (w_idle),
        .i_tick    (frame_tick_in),
        .o_step_en (w_step_en)
    );

    // Target is derived from the held ball position, so it stays valid through CHECK.
    always_comb begin
        w_tx   = r_bx;
        w_ty   = r_by;
        w_edge = 1'b0;
        case (r_dir)
            DIR_UP:    if (r_by == '0)    w_edge = 1'b1; else w_ty = r_by - 1'b1;
            DIR_DOWN:  if (r_by == Y_MAX) w_edge = 1'b1; else w_ty = r_by + 1'b1;
            DIR_LEFT:  if (r_bx == '0)    w_edge = 1'b1; else w_tx = r_bx - 1'b1;
            DIR_RIGHT: if (r_bx == X_MAX) w_edge = 1'b1; else w_tx = r_bx + 1'b1;
            default:   w_edge = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  if (w_go) w_state_nxt = ST_CALC;
            ST_CALC:  w_state_nxt = w_edge ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (r_wcnt == '0) w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (restart_in) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_bx       <= X_START;
            r_by       <= Y_START;
            r_map_addr <= '0;
            r_wcnt     <= '0;
            r_dir      <= DIR_UP;
            r_moved    <= 1'b0;
            r_bump     <= 1'b0;
            r_goal     <= 1'b0;
        end else begin
            r_moved <= 1'b0;
            r_bump  <= 1'b0;
            if (restart_in) begin
                r_bx   <= X_START;
                r_by   <= Y_START;
                r_goal <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_go) r_dir <= pick_dir(dir_in);
                    ST_CALC: begin
                        if (w_edge) begin
                            r_bump <= 1'b1;
                        end else begin
                            r_map_addr <= cell_addr(w_tx, w_ty, ADDR_W'(MAP_W));
                            r_wcnt     <= WC_W'(RD_LAT - 1);
                        end
                    end
                    ST_WAIT: if (r_wcnt != '0) r_wcnt <= r_wcnt - 1'b1;
                    ST_CHECK: begin
                        if (map_if.map_data_in == TILE_WALL) begin
                            r_bump <= 1'b1;
                        end else begin
                            r_bx    <= w_tx;
                            r_by    <= w_ty;
                            r_moved <= 1'b1;
                            if (map_if.map_data_in == TILE_GOAL) r_goal <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign map_if.map_addr_out = r_map_addr;
    assign ballx_out           = r_bx;
    assign bally_out           = r_by;
    assign busy_out            = w_busy;
    assign moved_out           = r_moved;
    assign bump_out            = r_bump;
    assign goal_out            = r_goal;

endmodule
